// File: rtl/wb_host_pkg.sv
// Shared types for the Wishbone classic host master.
// Command/response bundles and FSM state encoding.
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog counter for the host master.
// Flags expiry on the last allowed strobe cycle.
module wb_host_timeout #(
  parameter int TO_W           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TO_W-1:0] LAST = TO_W'(LAST_I);

  logic [TO_W-1:0] cnt_q;

  // Count stalled strobe cycles; clear restarts each bus cycle at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one bus cycle per command.
// Registered bus/response outputs with a no-ack timeout.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TO_W           = 8,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  wb_state_e state_q, state_d;
  wb_req_t   req_q, req_d;
  wb_rsp_t   rsp_q, rsp_d;
  logic      cyc_q, cyc_d;
  logic      rv_q, rv_d;
  logic      expired;

  wb_host_timeout #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_to (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clr     (state_q == IDLE),
    .en      ((state_q == BUS) && !wbm_ack_i),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode; ack takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = BUS;
      BUS:  if (wbm_ack_i || expired) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered bus and response outputs.
  always_comb begin
    req_d = req_q;
    rsp_d = rsp_q;
    cyc_d = cyc_q;
    rv_d  = rv_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          req_d.we  = cmd_we_i;
          req_d.adr = cmd_adr_i;
          req_d.dat = cmd_dat_i;
          req_d.sel = cmd_sel_i;
          cyc_d     = 1'b1;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          rv_d      = 1'b1;
          rsp_d.dat = req_q.we ? 32'h0 : wbm_dat_i;
          rsp_d.err = 1'b0;
        end else if (expired) begin
          cyc_d     = 1'b0;
          rv_d      = 1'b1;
          rsp_d.dat = req_q.we ? 32'h0 : ERR_DATA;
          rsp_d.err = 1'b1;
        end
      end
      RESP: if (rsp_ready_i) rv_d = 1'b0;
      default: begin
        cyc_d = 1'b0;
        rv_d  = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      req_q <= '0;
      rsp_q <= '0;
      cyc_q <= 1'b0;
      rv_q  <= 1'b0;
    end else begin
      req_q <= req_d;
      rsp_q <= rsp_d;
      cyc_q <= cyc_d;
      rv_q  <= rv_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rv_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = req_q.we;
  assign wbm_adr_o   = req_q.adr;
  assign wbm_dat_o   = req_q.dat;
  assign wbm_sel_o   = req_q.sel;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master.
// Hand-computed expectations, TIMEOUT_CYCLES=8.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;

  int nvec = 0;
  int nerr = 0;
  int stb_cnt = 0;
  int waited;

  wb_host_master #(
    .TIMEOUT_CYCLES (8),
    .TO_W           (8),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_sel_o   (sel),
    .wbm_dat_i   (rdat),
    .wbm_ack_i   (ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stb) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    stb_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; rdat = '0; ack = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_rdat", rsp_dat, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    chk("w_cyc", 32'(cyc), 32'd1);
    chk("w_stb", 32'(stb), 32'd1);
    chk("w_we", 32'(we), 32'd1);
    chk("w_adr", adr, 32'h3000_0004);
    chk("w_dat", wdat, 32'hA5A5_1234);
    chk("w_sel", 32'(sel), 32'hF);
    chk("w_rv1", 32'(rsp_valid), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("w_rv2", 32'(rsp_valid), 32'd1);
    chk("w_cyc2", 32'(cyc), 32'd0);
    chk("w_rdat", rsp_dat, 32'd0);
    chk("w_err", 32'(rsp_err), 32'd0);
    chk("w_stbn", 32'(stb_cnt), 32'd1);
    tick();
    chk("w_rv3", 32'(rsp_valid), 32'd0);
    chk("w_ready3", 32'(cmd_ready), 32'd1);

    // read with 3 wait states
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    chk("r_we", 32'(we), 32'd0);
    tick(); tick(); tick();
    ack = 1'b1; rdat = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; rdat = '0;
    chk("r_rv", 32'(rsp_valid), 32'd1);
    chk("r_rdat", rsp_dat, 32'hCAFE_F00D);
    chk("r_err", 32'(rsp_err), 32'd0);
    chk("r_stbn", 32'(stb_cnt), 32'd4);
    tick();

    // timeout, no ack
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("to_wait", 32'(waited), 32'd8);
    chk("to_rv", 32'(rsp_valid), 32'd1);
    chk("to_cyc", 32'(cyc), 32'd0);
    chk("to_stbn", 32'(stb_cnt), 32'd8);
    chk("to_rdat", rsp_dat, 32'hDEAD_BEEF);
    chk("to_err", 32'(rsp_err), 32'd1);
    tick();

    // ack on the last allowed stb cycle wins
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) tick();
    ack = 1'b1; rdat = 32'h1;
    tick();
    ack = 1'b0; rdat = '0;
    chk("la_rv", 32'(rsp_valid), 32'd1);
    chk("la_err", 32'(rsp_err), 32'd0);
    chk("la_rdat", rsp_dat, 32'h1);
    chk("la_stbn", 32'(stb_cnt), 32'd8);
    tick();

    // response backpressure with a pending second command
    rsp_ready = 1'b0;
    issue(1'b1, 32'h3000_0010, 32'h1111_2222, 4'h3);
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_adr = 32'h3000_0020; cmd_sel = 4'h1;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(rsp_valid), 32'd1);
      chk("bp_rdat", rsp_dat, 32'd0);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_cyc", 32'(cyc), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rv_off", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp2_cyc", 32'(cyc), 32'd1);
    chk("bp2_adr", adr, 32'h3000_0020);
    chk("bp2_we", 32'(we), 32'd0);
    ack = 1'b1; rdat = 32'h0BAD_F00D;
    tick();
    ack = 1'b0; rdat = '0;
    chk("bp2_rdat", rsp_dat, 32'h0BAD_F00D);
    tick();

    // async reset in BUS, late ack ignored
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    chk("ar_cyc1", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc", 32'(cyc), 32'd0);
    chk("ar_stb", 32'(stb), 32'd0);
    tick();
    rst_n = 1'b1;
    ack = 1'b1; rdat = 32'h5555_AAAA;
    tick(); tick();
    ack = 1'b0;
    chk("ar_ready", 32'(cmd_ready), 32'd1);
    chk("ar_rv", 32'(rsp_valid), 32'd0);
    chk("ar_cyc2", 32'(cyc), 32'd0);
    chk("ar_rdat", rsp_dat, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
